frame_bank_scheduler: RTL and testbench
=======================================

// Module: frame_bank_scheduler
// PURPOSE
// - Ping-pong scheduler for a 2-bank frame buffer (2*NUM_PIXELS words) between frame writer and BRAM->AXIS reader.
// - Grants writer one bank, reader the other; swaps at reader frame boundaries; repeats last frame if no new one ready.
// - Drives reader start pulses and bank base addresses; reader adds base to its pixel address.
// PARAMETERS
// NUM_PIXELS  720*480  words per frame/bank
// CNT_WIDTH   16       width of frame_count / repeat_count (wrap modulo 2^CNT_WIDTH)
// PORTS
// m00_axis_aclk     in   1   clock (shared with reader AXIS)
// m00_axis_aresetn  in   1   reset, asynchronous, active-low
// enable            in   1   level; scheduling runs while high
// wr_done           in   1   1-cycle pulse: writer finished a frame into wr_bank
// rd_done           in   1   1-cycle pulse: reader accepted tlast beat of current frame
// wr_ready          out  1   writer may write into wr_bank
// wr_bank           out  1   bank owned by writer
// rd_bank           out  1   bank owned by reader
// wr_base_addr      out  $clog2(2*NUM_PIXELS)  wr_bank*NUM_PIXELS
// rd_base_addr      out  $clog2(2*NUM_PIXELS)  rd_bank*NUM_PIXELS
// rd_start          out  1   1-cycle pulse: reader begins streaming rd_bank
// frame_count       out  CNT_WIDTH  frames started with new content
// repeat_count      out  CNT_WIDTH  frames re-sent (no new frame at boundary)
// err               out  1   sticky protocol-error flag
// probe_out         out  4   {err, state==DRAIN, state==STREAM, state==WAIT_FIRST}
// BEHAVIOUR
// - All outputs registered. Reset (async, any time incl. mid-frame): state=IDLE, wr_bank=0, rd_bank=1,
//   wr_ready=0, rd_start=0, pending=0, counters=0, err=0; base addrs follow banks (wr 0, rd NUM_PIXELS).
// - States: IDLE, WAIT_FIRST, STREAM, DRAIN. Event in cycle N -> outputs change in N+1 (1-cycle latency).
// - IDLE: enable=1 -> WAIT_FIRST, wr_ready=1. wr_done/rd_done ignored.
// - WAIT_FIRST: wr_done -> rd_bank<=wr_bank, wr_bank<=~wr_bank, rd_start pulse, frame_count++, -> STREAM.
//   rd_done here -> ignored, err<=1. enable=0 -> IDLE, wr_ready=0.
// - STREAM: wr_done sets pending; wr_ready=~pending. rd_done with pending (or wr_done same cycle):
//   swap wr_bank/rd_bank, pending<=0, rd_start, frame_count++. rd_done w/o pending: rd_start on same
//   rd_bank, repeat_count++. wr_done+rd_done same cycle = wr_done first, then swap.
// - wr_done while pending=1 (writer ignored wr_ready): no state change, err<=1.
// - enable=0 in STREAM -> DRAIN: current frame completes; wr_ready=0; on rd_done -> IDLE, no rd_start,
//   pending cleared, banks keep values. enable re-asserted in DRAIN does not cancel drain.
// - rd_start never asserted in two consecutive cycles; never asserted outside STREAM transitions/WAIT_FIRST exit.
// - Counters wrap at 2^CNT_WIDTH-1 -> 0. Base addr = bank ? NUM_PIXELS : 0.
// CONFIGURATION
// - FB_OVERWRITE_EN defined: latest-frame policy; wr_ready stays 1 in STREAM even with pending;
//   wr_done with pending=1 keeps pending=1, no err (newer frame replaces pending one in same bank).
// - FB_OVERWRITE_EN undefined: stall policy as above (wr_ready=~pending, overwrite -> err).
// TESTING
// 1 reset, enable=1, wr_done@10 -> rd_start@11 only, rd_bank=0, wr_bank=1, rd_base=0, wr_base=NUM_PIXELS, frame_count=1.
// 2 STREAM, wr_done@20, rd_done@40 -> wr_ready 0 from 21, rd_start@41, banks swap, wr_ready=1@41, frame_count=2.
// 3 STREAM, no wr_done, rd_done x3 -> 3 rd_start pulses, rd_bank unchanged, repeat_count=3, frame_count unchanged.
// 4 wr_done and rd_done same cycle in STREAM -> one rd_start, banks swap, pending=0, err=0.
// 5 wr_done twice w/o rd_done -> err=1 sticky (FB_OVERWRITE_EN off); err=0, wr_ready=1 (on).
// 6 enable=0 mid-frame -> DRAIN, wr_ready=0, rd_done -> IDLE, no rd_start; aresetn low mid-STREAM -> all reset values immediately.

Source files
------------

// File: rtl/frame_bank_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : fb_sched_if
// Brief   : Handshake/bus bundle between frame_bank_scheduler, the frame
//           writer and the BRAM->AXIS reader.
// Rev     : 1.0  initial release
// ============================================================================
interface fb_sched_if #(
  parameter int NUM_PIXELS = 720*480,
  parameter int CNT_WIDTH  = 16
);
  localparam int AW = $clog2(2*NUM_PIXELS);

  logic                 enable;
  logic                 wr_done;
  logic                 rd_done;
  logic                 wr_ready;
  logic                 wr_bank;
  logic                 rd_bank;
  logic [AW-1:0]        wr_base_addr;
  logic [AW-1:0]        rd_base_addr;
  logic                 rd_start;
  logic [CNT_WIDTH-1:0] frame_count;
  logic [CNT_WIDTH-1:0] repeat_count;
  logic                 err;
  logic [3:0]           probe_out;

  // Scheduler side
  modport master (
    input  enable, wr_done, rd_done,
    output wr_ready, wr_bank, rd_bank, wr_base_addr, rd_base_addr,
           rd_start, frame_count, repeat_count, err, probe_out
  );

  // Writer/reader/control side
  modport slave (
    output enable, wr_done, rd_done,
    input  wr_ready, wr_bank, rd_bank, wr_base_addr, rd_base_addr,
           rd_start, frame_count, repeat_count, err, probe_out
  );
endinterface
`default_nettype wire

// File: rtl/frame_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : frame_bank_scheduler
// Brief   : Ping-pong scheduler for a two-bank frame buffer. The writer owns
//           one bank, the reader the other; banks swap at reader frame
//           boundaries when a new frame is ready, otherwise the last frame is
//           re-sent. All outputs are registered (1-cycle latency).
// Config  : FB_OVERWRITE_EN - when defined, latest-frame policy (writer may
//           overwrite a pending frame; wr_ready stays high in STREAM).
//           Undefined: stall policy (wr_ready = ~pending, overwrite = err).
// Rev     : 1.0  initial release
// ============================================================================
module frame_bank_scheduler #(
  parameter int NUM_PIXELS = 720*480,
  parameter int CNT_WIDTH  = 16
) (
  input  wire logic   m00_axis_aclk,
  input  wire logic   m00_axis_aresetn,
  fb_sched_if.master  bus
);

  localparam int AW = $clog2(2*NUM_PIXELS);
  localparam logic [AW-1:0] BANK1_BASE = AW'(NUM_PIXELS);

`ifdef FB_OVERWRITE_EN
  localparam bit OVERWRITE = 1'b1;
`else
  localparam bit OVERWRITE = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_FIRST = 2'd1,
    S_STREAM     = 2'd2,
    S_DRAIN      = 2'd3
  } state_t;

  state_t               state_q,        state_d;
  logic                 wr_bank_q,      wr_bank_d;
  logic                 rd_bank_q,      rd_bank_d;
  logic                 pending_q,      pending_d;
  logic                 wr_ready_q,     wr_ready_d;
  logic                 rd_start_q,     rd_start_d;
  logic [CNT_WIDTH-1:0] frame_count_q,  frame_count_d;
  logic [CNT_WIDTH-1:0] repeat_count_q, repeat_count_d;
  logic                 err_q,          err_d;
  logic [AW-1:0]        wr_base_q,      wr_base_d;
  logic [AW-1:0]        rd_base_q,      rd_base_d;
  logic [3:0]           probe_q,        probe_d;

  // Next-state, bank ownership, counters and registered-output precompute
  always_comb begin
    state_d        = state_q;
    wr_bank_d      = wr_bank_q;
    rd_bank_d      = rd_bank_q;
    pending_d      = pending_q;
    rd_start_d     = 1'b0;
    frame_count_d  = frame_count_q;
    repeat_count_d = repeat_count_q;
    err_d          = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.enable) state_d = S_WAIT_FIRST;
      end

      S_WAIT_FIRST: begin
        // Reader has nothing to finish yet: a done pulse is a protocol error
        if (bus.rd_done) err_d = 1'b1;
        if (!bus.enable) begin
          state_d = S_IDLE;
        end else if (bus.wr_done) begin
          rd_bank_d     = wr_bank_q;
          wr_bank_d     = ~wr_bank_q;
          rd_start_d    = 1'b1;
          frame_count_d = frame_count_q + 1'b1;
          state_d       = S_STREAM;
        end
      end

      S_STREAM: begin
        // Writer completion is folded in first so a same-cycle rd_done swaps
        if (bus.wr_done) begin
          if (pending_q && !OVERWRITE) err_d = 1'b1;
          pending_d = 1'b1;
        end
        if (bus.rd_done && rd_start_q) begin
          // A frame cannot end the cycle after it started; drop and flag it
          err_d = 1'b1;
        end else if (bus.rd_done) begin
          if (!bus.enable) begin
            // Disable coincides with frame end: the drain is already done
            state_d   = S_IDLE;
            pending_d = 1'b0;
          end else if (pending_d) begin
            wr_bank_d     = rd_bank_q;
            rd_bank_d     = wr_bank_q;
            pending_d     = 1'b0;
            rd_start_d    = 1'b1;
            frame_count_d = frame_count_q + 1'b1;
          end else begin
            rd_start_d     = 1'b1;
            repeat_count_d = repeat_count_q + 1'b1;
          end
        end else if (!bus.enable) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (bus.wr_done) begin
          if (pending_q && !OVERWRITE) err_d = 1'b1;
          pending_d = 1'b1;
        end
        // Let the current frame finish, then park without restarting
        if (bus.rd_done) begin
          state_d   = S_IDLE;
          pending_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_WAIT_FIRST: wr_ready_d = 1'b1;
      S_STREAM:     wr_ready_d = OVERWRITE ? 1'b1 : ~pending_d;
      default:      wr_ready_d = 1'b0;
    endcase

    wr_base_d = wr_bank_d ? BANK1_BASE : '0;
    rd_base_d = rd_bank_d ? BANK1_BASE : '0;
    probe_d   = {err_d, state_d == S_DRAIN, state_d == S_STREAM,
                 state_d == S_WAIT_FIRST};
  end

  // State and output registers, asynchronously reset at any point in a frame
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state_q        <= S_IDLE;
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b1;
      pending_q      <= 1'b0;
      wr_ready_q     <= 1'b0;
      rd_start_q     <= 1'b0;
      frame_count_q  <= '0;
      repeat_count_q <= '0;
      err_q          <= 1'b0;
      wr_base_q      <= '0;
      rd_base_q      <= BANK1_BASE;
      probe_q        <= '0;
    end else begin
      state_q        <= state_d;
      wr_bank_q      <= wr_bank_d;
      rd_bank_q      <= rd_bank_d;
      pending_q      <= pending_d;
      wr_ready_q     <= wr_ready_d;
      rd_start_q     <= rd_start_d;
      frame_count_q  <= frame_count_d;
      repeat_count_q <= repeat_count_d;
      err_q          <= err_d;
      wr_base_q      <= wr_base_d;
      rd_base_q      <= rd_base_d;
      probe_q        <= probe_d;
    end
  end

  assign bus.wr_ready     = wr_ready_q;
  assign bus.wr_bank      = wr_bank_q;
  assign bus.rd_bank      = rd_bank_q;
  assign bus.wr_base_addr = wr_base_q;
  assign bus.rd_base_addr = rd_base_q;
  assign bus.rd_start     = rd_start_q;
  assign bus.frame_count  = frame_count_q;
  assign bus.repeat_count = repeat_count_q;
  assign bus.err          = err_q;
  assign bus.probe_out    = probe_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_frame_bank_scheduler
// Brief   : Directed self-checking bench for frame_bank_scheduler.
// Rev     : 1.0  initial release
// ============================================================================
module tb_frame_bank_scheduler;

  localparam int NP = 720*480;
  localparam int CW = 4;
`ifdef FB_OVERWRITE_EN
  localparam bit OVW = 1'b1;
`else
  localparam bit OVW = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   rs_cnt = 0;
  logic rs_prev = 1'b0;

  always #5 clk = ~clk;

  fb_sched_if #(.NUM_PIXELS(NP), .CNT_WIDTH(CW)) bus ();

  frame_bank_scheduler #(.NUM_PIXELS(NP), .CNT_WIDTH(CW)) dut (
    .m00_axis_aclk    (clk),
    .m00_axis_aresetn (rst_n),
    .bus              (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic w, input logic r);
    bus.wr_done = w;
    bus.rd_done = r;
    step(1);
    bus.wr_done = 1'b0;
    bus.rd_done = 1'b0;
  endtask

  // Count rd_start pulses and catch back-to-back assertion
  always @(negedge clk) begin
    if (rst_n && bus.rd_start) begin
      chk("rd_start_gap", 32'(rs_prev), 32'd0);
      rs_cnt++;
    end
    rs_prev = rst_n && bus.rd_start;
  end

  initial begin
    bus.enable  = 1'b0;
    bus.wr_done = 1'b0;
    bus.rd_done = 1'b0;
    step(2);

    // Reset values
    chk("rst_wr_bank",  32'(bus.wr_bank), 32'd0);
    chk("rst_rd_bank",  32'(bus.rd_bank), 32'd1);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("rst_rd_start", 32'(bus.rd_start), 32'd0);
    chk("rst_fc",       32'(bus.frame_count), 32'd0);
    chk("rst_rc",       32'(bus.repeat_count), 32'd0);
    chk("rst_err",      32'(bus.err), 32'd0);
    chk("rst_wr_base",  32'(bus.wr_base_addr), 32'd0);
    chk("rst_rd_base",  32'(bus.rd_base_addr), 32'(NP));
    chk("rst_probe",    32'(bus.probe_out), 32'd0);

    rst_n = 1'b1;
    step(2);
    chk("idle_probe", 32'(bus.probe_out), 32'd0);

    // Enable -> WAIT_FIRST
    bus.enable = 1'b1;
    step(1);
    chk("wf_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("wf_probe",    32'(bus.probe_out), 32'b0001);

    // Test 1: first frame
    step(3);
    pulse(1'b1, 1'b0);
    chk("t1_rd_start", 32'(bus.rd_start), 32'd1);
    chk("t1_rd_bank",  32'(bus.rd_bank), 32'd0);
    chk("t1_wr_bank",  32'(bus.wr_bank), 32'd1);
    chk("t1_rd_base",  32'(bus.rd_base_addr), 32'd0);
    chk("t1_wr_base",  32'(bus.wr_base_addr), 32'(NP));
    chk("t1_fc",       32'(bus.frame_count), 32'd1);
    chk("t1_probe",    32'(bus.probe_out), 32'b0010);
    step(1);
    chk("t1_rd_start_low", 32'(bus.rd_start), 32'd0);
    chk("t1_rs_cnt", 32'(rs_cnt), 32'd1);

    // Test 2: new frame pending, swap at frame end
    step(5);
    pulse(1'b1, 1'b0);
    chk("t2_wr_ready_pend", 32'(bus.wr_ready), OVW ? 32'd1 : 32'd0);
    step(10);
    chk("t2_wr_ready_hold", 32'(bus.wr_ready), OVW ? 32'd1 : 32'd0);
    chk("t2_rd_start_idle", 32'(bus.rd_start), 32'd0);
    pulse(1'b0, 1'b1);
    chk("t2_rd_start", 32'(bus.rd_start), 32'd1);
    chk("t2_rd_bank",  32'(bus.rd_bank), 32'd1);
    chk("t2_wr_bank",  32'(bus.wr_bank), 32'd0);
    chk("t2_rd_base",  32'(bus.rd_base_addr), 32'(NP));
    chk("t2_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("t2_fc",       32'(bus.frame_count), 32'd2);
    step(1);

    // Test 3: repeats with no new frame
    for (int i = 0; i < 3; i++) begin
      step(4);
      pulse(1'b0, 1'b1);
      chk("t3_rd_start", 32'(bus.rd_start), 32'd1);
      chk("t3_rd_bank",  32'(bus.rd_bank), 32'd1);
    end
    step(1);
    chk("t3_rc",     32'(bus.repeat_count), 32'd3);
    chk("t3_fc",     32'(bus.frame_count), 32'd2);
    chk("t3_rs_cnt", 32'(rs_cnt), 32'd5);

    // Test 4: wr_done and rd_done in the same cycle
    step(3);
    pulse(1'b1, 1'b1);
    chk("t4_rd_start", 32'(bus.rd_start), 32'd1);
    chk("t4_rd_bank",  32'(bus.rd_bank), 32'd0);
    chk("t4_wr_bank",  32'(bus.wr_bank), 32'd1);
    chk("t4_fc",       32'(bus.frame_count), 32'd3);
    chk("t4_err",      32'(bus.err), 32'd0);
    chk("t4_wr_ready", 32'(bus.wr_ready), 32'd1);
    step(1);
    chk("t4_rs_cnt", 32'(rs_cnt), 32'd6);

    // Repeat counter wraps: 3 + 13 = 16 -> 0 at CNT_WIDTH=4
    for (int i = 0; i < 13; i++) begin
      step(2);
      pulse(1'b0, 1'b1);
    end
    step(1);
    chk("wrap_rc",      32'(bus.repeat_count), 32'd0);
    chk("wrap_rd_bank", 32'(bus.rd_bank), 32'd0);
    chk("wrap_rs_cnt",  32'(rs_cnt), 32'd19);

    // Test 5: writer overwrites a pending frame
    pulse(1'b1, 1'b0);
    step(2);
    pulse(1'b1, 1'b0);
    chk("t5_err",      32'(bus.err), OVW ? 32'd0 : 32'd1);
    chk("t5_wr_ready", 32'(bus.wr_ready), OVW ? 32'd1 : 32'd0);
    chk("t5_probe",    32'(bus.probe_out), OVW ? 32'b0010 : 32'b1010);
    step(2);
    pulse(1'b0, 1'b1);
    chk("t5_rd_bank",  32'(bus.rd_bank), 32'd1);
    chk("t5_wr_bank",  32'(bus.wr_bank), 32'd0);
    chk("t5_fc",       32'(bus.frame_count), 32'd4);
    chk("t5_wr_ready", 32'(bus.wr_ready), 32'd1);
    step(3);
    chk("t5_err_sticky", 32'(bus.err), OVW ? 32'd0 : 32'd1);

    // Test 6: disable mid-frame -> DRAIN, re-enable does not cancel
    bus.enable = 1'b0;
    step(1);
    chk("t6_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("t6_drain",    32'(bus.probe_out[2:0]), 32'b100);
    bus.enable = 1'b1;
    step(3);
    chk("t6_drain_hold", 32'(bus.probe_out[2:0]), 32'b100);
    bus.enable = 1'b0;
    pulse(1'b0, 1'b1);
    chk("t6_no_start", 32'(bus.rd_start), 32'd0);
    step(1);
    chk("t6_idle",     32'(bus.probe_out[2:0]), 32'b000);
    chk("t6_rs_cnt",   32'(rs_cnt), 32'd20);
    chk("t6_rd_bank",  32'(bus.rd_bank), 32'd1);
    chk("t6_wr_bank",  32'(bus.wr_bank), 32'd0);

    // rd_done in WAIT_FIRST is an error and starts nothing
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    bus.enable = 1'b1;
    step(1);
    pulse(1'b0, 1'b1);
    chk("wf_err",      32'(bus.err), 32'd1);
    chk("wf_no_start", 32'(bus.rd_start), 32'd0);
    chk("wf_probe_err", 32'(bus.probe_out), 32'b1001);

    // Asynchronous reset in the middle of a streamed frame
    pulse(1'b1, 1'b0);
    chk("ar_fc_pre", 32'(bus.frame_count), 32'd1);
    step(3);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_probe",    32'(bus.probe_out), 32'd0);
    chk("ar_rd_bank",  32'(bus.rd_bank), 32'd1);
    chk("ar_wr_bank",  32'(bus.wr_bank), 32'd0);
    chk("ar_fc",       32'(bus.frame_count), 32'd0);
    chk("ar_err",      32'(bus.err), 32'd0);
    chk("ar_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("ar_rd_base",  32'(bus.rd_base_addr), 32'(NP));
    chk("ar_wr_base",  32'(bus.wr_base_addr), 32'd0);
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
